// File: rtl/mem_pkg.sv
// Shared types and constants for the memory read responder.
// Burst-mode definitions are present only when MEM_BURST_EN is defined.
package mem_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned WORD_SHIFT = 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hfff0;

`ifdef MEM_BURST_EN
    localparam int unsigned BURST_LEN   = 8;
    localparam int unsigned BURST_CNT_W = $clog2(BURST_LEN);

    typedef enum logic {
        BURST_IDLE,
        BURST_ISSUE
    } burst_state_t;
`endif

    // One in-flight read response.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_resp_t;

    // Base byte address of the 16-byte block containing a.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
        return a & BLOCK_MASK;
    endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-depth shift register of read responses with synchronous clear.
module mem_delay_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  mem_resp_t din,
    output mem_resp_t dout
);

    mem_resp_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_read_responder.sv
// 64 KB word memory with fixed pipelined read latency and address echo.
// Defining MEM_BURST_EN turns each accepted read into an 8-word block burst.
module mem_read_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] data_addr,
    output logic              busy
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              rd_issue_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    mem_resp_t         req_resp_c;
    mem_resp_t         pipe_out;
    logic              unused_addr_lsb;

`ifdef MEM_BURST_EN
    burst_state_t           state_q, state_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]      base_q, base_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BURST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Word 0 issues on the accepting cycle; words 1..7 follow while busy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        rd_issue_c = 1'b0;
        wr_en_c    = 1'b0;
        rd_addr_c  = addr;
        case (state_q)
            BURST_IDLE: begin
                if (enable && wr) begin
                    wr_en_c = 1'b1;
                end else if (enable) begin
                    rd_issue_c = 1'b1;
                    rd_addr_c  = block_base(addr);
                    base_d     = block_base(addr);
                    cnt_d      = BURST_CNT_W'(1);
                    state_d    = BURST_ISSUE;
                end
            end
            BURST_ISSUE: begin
                rd_issue_c = 1'b1;
                rd_addr_c  = base_q | ADDR_W'({cnt_q, 1'b0});
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == BURST_CNT_W'(BURST_LEN - 1)) begin
                    state_d = BURST_IDLE;
                end
            end
            default: state_d = BURST_IDLE;
        endcase
    end

    assign busy = (state_q == BURST_ISSUE);
`else
    always_comb begin
        rd_issue_c = enable & ~wr;
        wr_en_c    = enable & wr;
        rd_addr_c  = addr;
    end

    assign busy = 1'b0;
`endif

    // Memory contents survive reset; only requests made out of reset commit.
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) begin
            mem[addr[ADDR_W-1:WORD_SHIFT]] <= data_in;
        end
    end

    always_comb begin
        req_resp_c       = '0;
        req_resp_c.valid = rd_issue_c;
        req_resp_c.addr  = {rd_addr_c[ADDR_W-1:WORD_SHIFT], 1'b0};
        req_resp_c.data  = mem[rd_addr_c[ADDR_W-1:WORD_SHIFT]];
    end

    assign unused_addr_lsb = rd_addr_c[0];

    mem_delay_pipe #(
        .DEPTH (LATENCY)
    ) u_delay_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (req_resp_c),
        .dout (pipe_out)
    );

    // Output stage: strobe every cycle, data and address hold between words.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_out   <= '0;
            data_addr  <= '0;
        end else begin
            data_valid <= pipe_out.valid;
            if (pipe_out.valid) begin
                data_out  <= pipe_out.data;
                data_addr <= pipe_out.addr;
            end
        end
    end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Memory-side responder for the cache fill path: a 64 KB main memory with 16-bit words, byte addresses and a fixed 4-cycle pipelined read latency.
- Accepts one request per cycle from the cache controller, either a read or a write-through write.
- Returns read data with a one-cycle valid strobe and an echo of the request address.
- The cache fill FSM uses the echoed address to place each returning word in its block.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width; one word is 2 bytes.
- LATENCY, 4, read latency in cycles from request to data_valid; legal range 1..8.
- MEM_WORDS, 32768, word capacity, equal to 2^(ADDR_W-1).
- BURST_LEN, 8, words per burst (a 16-byte block); used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request valid this cycle.
- wr  in  1  1 = write, 0 = read; qualified by enable.
- addr  in  16  byte address; addr[0] is ignored, word index = addr[15:1].
- data_in  in  16  write data.
- data_out  out  16  read data; meaningful only while data_valid=1.
- data_valid  out  1  one-cycle strobe, one per returned word.
- data_addr  out  16  word-aligned address of the word on data_out.
- busy  out  1  high while a burst is issuing; always 0 without the feature.

Behaviour:
- Reset (one clock is synchronous and active-high; reset is synchronous, active-high on rst):
  - data_valid=0, data_out=0, data_addr=0, busy=0.
  - All in-flight pipeline stages are cleared.
  - Memory contents are NOT reset.
  - Reset mid-operation discards every outstanding read and any active burst; no data_valid follows.
- Read:
  - enable=1, wr=0 sampled at edge N reads the array at N.
  - data_valid=1 exactly at edge N+LATENCY, with data_out = mem[addr[15:1]] as of N and data_addr = {addr[15:1],1'b0}.
- Write:
  - enable=1, wr=1 at edge N commits data_in to mem[addr[15:1]] at edge N.
  - A write produces no response.
  - A read issued at N+1 or later returns the new value.
- Pipelining:
  - Back-to-back reads, one per cycle, are fully pipelined, giving one data_valid per cycle after the latency.
  - Responses return in issue order.
  - At most LATENCY reads are in flight; there is no backpressure.
- Read/write interleave: a write between two reads does not disturb the earlier read's captured data.
- Single port: only one request per cycle.
- Address wrap: there is no bound check; addresses cover the full 64 KB.
- data_out holds its last value when data_valid=0.

Optional Feature:
Macro MEM_BURST_EN.
- With the macro:
  - A read accepted while busy=0 latches base = addr & 16'hfff0.
  - It internally issues BURST_LEN reads at base, base+2, … base+14 on consecutive cycles, starting the cycle of acceptance.
  - busy=1 from the cycle after acceptance until the last internal read has issued.
  - Word k returns at N+LATENCY+k; the last word returns at N+LATENCY+7.
  - Any enable (read or write) while busy=1 is ignored and has no effect.
  - Writes while busy=0 behave as without the macro.
  - A 3-bit burst counter wraps 7→0 and deasserts busy.
- Without the macro: the counter logic is absent, busy is tied to 0, and each read returns a single word.

Decomposition:
- Package mem_pkg holds:
  - constants ADDR_W, DATA_W, WORD_SHIFT=1, BLOCK_MASK=16'hfff0;
  - a response struct type {valid, addr, data}.
- Sub-module mem_delay_pipe: a LATENCY-deep shift register of response structs with synchronous clear. It is the natural split and is reused for any other latency path.
- The top level holds the array, request decode and burst counter.

Test Plan:
1. Reset then idle, rst high 3 cycles → data_valid=0, busy=0, data_out=0 throughout. Memory contents persist across a second reset: write 0xBEEF@0x0010, reset, read 0x0010 → 0xBEEF.
2. Write 0x1234@0x0100 at cycle 5, read 0x0100 at cycle 6 → data_valid only at cycle 10, data_out=0x1234, data_addr=0x0100.
3. Preload 8 words 0xA000..0xA007 at 0x0200..0x020E, then read the 8 addresses at cycles 20..27 → data_valid high cycles 24..31, in order, data_addr sequence 0x0200..0x020E.
4. Read 0x0301 (odd) → returns word at 0x0300, data_addr=0x0300. Read 0xFFFE → top word returned.
5. Issue reads at cycles 40,41; assert rst at 42 → no data_valid at 44/45; next read after reset returns normally.
6. MEM_BURST_EN: read 0x020A at cycle 50 → busy=1 cycles 51..57; data_valid cycles 54..61 with addresses 0x0200..0x020E; a write at cycle 53 is ignored (memory unchanged).
